// File: rtl/sdram_rw_sched_if.sv
// Scheduler <-> SDRAM controller / FIFO bundle.
// master: the scheduler; slave: controller and FIFO side.
interface sdram_rw_sched_if;
  logic [9:0]  wr_fifo_usedw;
  logic [9:0]  rd_fifo_usedw;
  logic        rd_enable;
  logic        Wr_data_vaild;
  logic        Rd_data_vaild;
  logic        WRITE_done;
  logic        READ_done;
  logic        Wr;
  logic        Rd;
  logic [12:0] caddr;
  logic [12:0] raddr;
  logic [1:0]  baddr;
  logic        wr_fifo_rden;
  logic        rd_fifo_wren;
  logic        frame_wr_done;

  modport master (
    input  wr_fifo_usedw, rd_fifo_usedw, rd_enable, Wr_data_vaild, Rd_data_vaild,
           WRITE_done, READ_done,
    output Wr, Rd, caddr, raddr, baddr, wr_fifo_rden, rd_fifo_wren, frame_wr_done
  );

  modport slave (
    output wr_fifo_usedw, rd_fifo_usedw, rd_enable, Wr_data_vaild, Rd_data_vaild,
           WRITE_done, READ_done,
    input  Wr, Rd, caddr, raddr, baddr, wr_fifo_rden, rd_fifo_wren, frame_wr_done
  );
endinterface

// File: rtl/sdram_rw_sched.sv
// SDRAM burst read/write scheduler: round-robin between the UART write FIFO
// and the TFT read FIFO, one burst at a time, with per-path frame burst index.
// Optional macro SCHED_PINGPONG_EN: write and read frames ping-pong between
// banks 0 and 1; without it every access goes to bank 0.
module sdram_rw_sched #(
  parameter int BURST_LEN    = 8,
  parameter int FRAME_BURSTS = 16320,
  parameter int RD_LOW       = 256
) (
  input  logic            clk_100m,
  input  logic            rst_n,
  sdram_rw_sched_if.master bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;

  localparam logic [9:0]  BL_LVL   = 10'(BURST_LEN);
  localparam logic [9:0]  RD_LVL   = 10'(RD_LOW);
  localparam logic [18:0] LAST_IDX = 19'(FRAME_BURSTS - 1);

  logic [2:0]  state;
  logic        favour_wr;
  logic [18:0] wr_idx, rd_idx, sel_idx;
  logic        wr_elig, rd_elig, grant_wr;
  logic        wr_done_evt, rd_done_evt;
  logic [1:0]  wr_bank, rd_bank;

  assign wr_elig  = bus.wr_fifo_usedw >= BL_LVL;
  assign rd_elig  = bus.rd_enable && (bus.rd_fifo_usedw <= RD_LVL);
  // a lone eligible path wins; on a tie the pointer decides
  assign grant_wr = wr_elig && (!rd_elig || favour_wr);
  assign sel_idx  = grant_wr ? wr_idx : rd_idx;

  // done pulses only count in the matching wait state
  assign wr_done_evt = (state == WR_WAIT) && bus.WRITE_done;
  assign rd_done_evt = (state == RD_WAIT) && bus.READ_done;

  assign bus.Wr           = (state == WR_REQ);
  assign bus.Rd           = (state == RD_REQ);
  assign bus.wr_fifo_rden = bus.Wr_data_vaild;
  assign bus.rd_fifo_wren = bus.Rd_data_vaild;

  // scheduler FSM, round-robin pointer and address latch at grant time
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      favour_wr <= 1'b1;
      bus.caddr <= '0;
      bus.raddr <= '0;
      bus.baddr <= '0;
    end else begin
      case (state)
        IDLE: if (wr_elig || rd_elig) begin
          state     <= grant_wr ? WR_REQ : RD_REQ;
          favour_wr <= !grant_wr;
          bus.caddr <= {4'b0000, sel_idx[5:0], 3'b000};
          bus.raddr <= sel_idx[18:6];
          bus.baddr <= grant_wr ? wr_bank : rd_bank;
        end
        WR_REQ:  if (bus.Wr_data_vaild) state <= WR_WAIT;
        WR_WAIT: if (bus.WRITE_done)    state <= IDLE;
        RD_REQ:  if (bus.Rd_data_vaild) state <= RD_WAIT;
        RD_WAIT: if (bus.READ_done)     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // per-path burst indices; end-of-frame pulse on the last write burst
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx            <= '0;
      rd_idx            <= '0;
      bus.frame_wr_done <= 1'b0;
    end else begin
      bus.frame_wr_done <= wr_done_evt && (wr_idx == LAST_IDX);
      if (wr_done_evt) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 19'd1;
      if (rd_done_evt) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 19'd1;
    end
  end

`ifdef SCHED_PINGPONG_EN
  logic wr_bank_q, rd_bank_q, done_bank, frame_seen;

  // write bank flips per finished frame; reads follow at their own frame wrap
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      done_bank  <= 1'b0;
      frame_seen <= 1'b0;
    end else begin
      if (wr_done_evt && (wr_idx == LAST_IDX)) begin
        wr_bank_q  <= ~wr_bank_q;
        done_bank  <= wr_bank_q;
        frame_seen <= 1'b1;
      end
      if (rd_done_evt && (rd_idx == LAST_IDX))
        rd_bank_q <= frame_seen ? done_bank : 1'b1;
    end
  end

  assign wr_bank = {1'b0, wr_bank_q};
  assign rd_bank = {1'b0, rd_bank_q};
`else
  assign wr_bank = 2'b00;
  assign rd_bank = 2'b00;
`endif
endmodule
